// File: rtl/riscv_alu_pkg.sv
// Shared definitions for the RV32I ALU: operation encodings and width constants.
// Operation codes are {funct7[5], funct3} of the instruction.
package alu_pkg;

  localparam int XLEN    = 32;
  localparam int SHAMT_W = 5;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_SUB  = 4'b1000,
    ALU_SLL  = 4'b0001,
    ALU_SLT  = 4'b0010,
    ALU_SLTU = 4'b0011,
    ALU_XOR  = 4'b0100,
    ALU_SRL  = 4'b0101,
    ALU_OR   = 4'b0110,
    ALU_AND  = 4'b0111,
    ALU_SRA  = 4'b1101
  } alu_op_e;

endpackage

// File: rtl/riscv_alu_if.sv
// Operand/result bundle between the execute stage and the ALU.
// With ALU_BRANCH_CMP_EN defined the bundle also carries eq/lt/ltu for the branch unit.
interface riscv_alu_if
  import alu_pkg::*;
#(
  parameter int WIDTH = XLEN
);

  logic [WIDTH-1:0] Op1;
  logic [WIDTH-1:0] Op2;
  logic [3:0]       ALU_op;
  logic [WIDTH-1:0] res;
  logic [WIDTH-1:0] res_q;
  logic             zero_q;
`ifdef ALU_BRANCH_CMP_EN
  logic             eq;
  logic             lt;
  logic             ltu;

  modport master (output Op1, Op2, ALU_op,
                  input  res, res_q, zero_q, eq, lt, ltu);
  modport slave  (input  Op1, Op2, ALU_op,
                  output res, res_q, zero_q, eq, lt, ltu);
`else
  modport master (output Op1, Op2, ALU_op,
                  input  res, res_q, zero_q);
  modport slave  (input  Op1, Op2, ALU_op,
                  output res, res_q, zero_q);
`endif

endinterface

// File: rtl/riscv_alu_shifter.sv
// Barrel shifter for SLL/SRL/SRA. Left shifts reuse the right-shift path by
// bit-reversing the operand on the way in and the result on the way out.
module alu_shifter
  import alu_pkg::*;
#(
  parameter int WIDTH   = XLEN,
  parameter int SHAMT_W = 5
) (
  input  logic [WIDTH-1:0]   data,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic               dir_right,
  input  logic               arith,
  output logic [WIDTH-1:0]   result
);

  logic [WIDTH-1:0]       src;
  logic [WIDTH-1:0]       shifted;
  logic                   fill;
  logic signed [WIDTH:0]  ext;
  logic signed [WIDTH:0]  ext_shifted;

  always_comb begin
    src = data;
    if (!dir_right) begin
      for (int i = 0; i < WIDTH; i++) begin
        src[i] = data[WIDTH-1-i];
      end
    end
  end

  // The extra top bit carries the fill value so one arithmetic shift covers both zero and sign fill.
  assign fill        = arith & dir_right & data[WIDTH-1];
  assign ext         = {fill, src};
  assign ext_shifted = ext >>> shamt;
  assign shifted     = ext_shifted[WIDTH-1:0];

  always_comb begin
    result = shifted;
    if (!dir_right) begin
      for (int i = 0; i < WIDTH; i++) begin
        result[i] = shifted[WIDTH-1-i];
      end
    end
  end

endmodule

// File: rtl/riscv_alu.sv
// RV32I execute-stage ALU: combinational res plus a registered res_q/zero_q copy.
// Optional macro ALU_BRANCH_CMP_EN adds op-independent eq/lt/ltu compare outputs.
module riscv_alu
  import alu_pkg::*;
#(
  parameter int WIDTH   = XLEN,
  parameter int SHAMT_W = 5
) (
  input  logic        clk,
  input  logic        reset,
  riscv_alu_if.slave  bus
);

  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;
  logic [WIDTH-1:0] shift_out;
  logic [WIDTH-1:0] res_c;
  logic             lt_s;
  logic             lt_u;

  assign sum  = bus.Op1 + bus.Op2;
  assign diff = bus.Op1 - bus.Op2;
  assign lt_s = $signed(bus.Op1) < $signed(bus.Op2);
  assign lt_u = bus.Op1 < bus.Op2;

  // ALU_op[2] separates SRL/SRA from SLL; ALU_op[3] (funct7[5]) selects sign fill.
  alu_shifter #(
    .WIDTH   (WIDTH),
    .SHAMT_W (SHAMT_W)
  ) u_shifter (
    .data      (bus.Op1),
    .shamt     (bus.Op2[SHAMT_W-1:0]),
    .dir_right (bus.ALU_op[2]),
    .arith     (bus.ALU_op[3]),
    .result    (shift_out)
  );

  always_comb begin
    res_c = '0;
    case (bus.ALU_op)
      ALU_ADD:  res_c = sum;
      ALU_SUB:  res_c = diff;
      ALU_SLL:  res_c = shift_out;
      ALU_SLT:  res_c = {{(WIDTH-1){1'b0}}, lt_s};
      ALU_SLTU: res_c = {{(WIDTH-1){1'b0}}, lt_u};
      ALU_XOR:  res_c = bus.Op1 ^ bus.Op2;
      ALU_SRL:  res_c = shift_out;
      ALU_OR:   res_c = bus.Op1 | bus.Op2;
      ALU_AND:  res_c = bus.Op1 & bus.Op2;
      ALU_SRA:  res_c = shift_out;
      default:  res_c = '0;
    endcase
  end

  assign bus.res = res_c;

  always_ff @(posedge clk) begin
    if (reset) begin
      bus.res_q  <= '0;
      bus.zero_q <= 1'b1;
    end else begin
      bus.res_q  <= res_c;
      bus.zero_q <= (res_c == '0);
    end
  end

`ifdef ALU_BRANCH_CMP_EN
  assign bus.eq  = (bus.Op1 == bus.Op2);
  assign bus.lt  = lt_s;
  assign bus.ltu = lt_u;
`endif

endmodule

// File: tb/tb_riscv_alu.sv
// Directed and random self-checking bench for riscv_alu (covers ALU_BRANCH_CMP_EN when defined).
module tb_riscv_alu;

  logic clk;
  logic reset;
  int   n_tests;
  int   n_fail;

  riscv_alu_if #(.WIDTH(32)) alu_bus ();

  riscv_alu #(.WIDTH(32), .SHAMT_W(5)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (alu_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Independent reference: signed compare by sign inspection, SRA via a 64-bit sign-extended shift.
  function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] wide;
    logic [4:0]  sh;
    logic [31:0] r;
    sh   = b[4:0];
    wide = '0;
    r    = '0;
    case (op)
      4'b0000: begin wide = {32'b0, a} + {32'b0, b}; r = wide[31:0]; end
      4'b1000: r = a + ~b + 32'd1;
      4'b0001: r = a << sh;
      4'b0010: r = (a[31] != b[31]) ? {31'b0, a[31]} : {31'b0, a < b};
      4'b0011: r = {31'b0, a < b};
      4'b0100: r = a ^ b;
      4'b0101: r = a >> sh;
      4'b0110: r = a | b;
      4'b0111: r = a & b;
      4'b1101: begin wide = {{32{a[31]}}, a} >> sh; r = wide[31:0]; end
      default: r = '0;
    endcase
    return r;
  endfunction

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic apply_stimulus(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    alu_bus.ALU_op = op;
    alu_bus.Op1    = a;
    alu_bus.Op2    = b;
    #1;
  endtask

  task automatic clock_edge();
    @(posedge clk);
    #1;
  endtask

  logic [3:0]  ops [10] = '{4'b0000, 4'b1000, 4'b0001, 4'b0010, 4'b0011,
                            4'b0100, 4'b0101, 4'b0110, 4'b0111, 4'b1101};
  logic [3:0]  undef_ops [6] = '{4'b1001, 4'b1010, 4'b1011, 4'b1100, 4'b1110, 4'b1111};
  logic [31:0] exp_prev;
  logic [31:0] ra;
  logic [31:0] rb;
  logic [3:0]  rop;

  initial begin
    n_tests = 0;
    n_fail  = 0;
    reset   = 1'b1;
    alu_bus.ALU_op = 4'b0000;
    alu_bus.Op1    = 32'h0000_0003;
    alu_bus.Op2    = 32'h0000_0004;

    // Power-on reset
    clock_edge();
    clock_edge();
    check_output("reset_res_q", alu_bus.res_q, 32'h0);
    check_output("reset_zero_q", {31'b0, alu_bus.zero_q}, 32'h1);
    check_output("reset_res_comb", alu_bus.res, 32'h7);
    reset = 1'b0;

    // Nonzero load so the following zero_q=1 is a real transition
    apply_stimulus(4'b0000, 32'h0000_0001, 32'h0000_0001);
    check_output("add_1_1", alu_bus.res, 32'h2);
    clock_edge();
    check_output("add_1_1_res_q", alu_bus.res_q, 32'h2);
    check_output("add_1_1_zero_q", {31'b0, alu_bus.zero_q}, 32'h0);

    apply_stimulus(4'b0000, 32'hFFFF_FFFF, 32'h0000_0001);
    check_output("add_wrap", alu_bus.res, 32'h0);
    clock_edge();
    check_output("add_wrap_res_q", alu_bus.res_q, 32'h0);
    check_output("add_wrap_zero_q", {31'b0, alu_bus.zero_q}, 32'h1);

    apply_stimulus(4'b1000, 32'h0000_0000, 32'h0000_0001);
    check_output("sub_wrap", alu_bus.res, 32'hFFFF_FFFF);
    apply_stimulus(4'b1000, 32'h0000_0010, 32'h0000_0003);
    check_output("sub_small", alu_bus.res, 32'h0000_000D);

    apply_stimulus(4'b0010, 32'h8000_0000, 32'h0000_0001);
    check_output("slt_neg_pos", alu_bus.res, 32'h1);
    apply_stimulus(4'b0011, 32'h8000_0000, 32'h0000_0001);
    check_output("sltu_neg_pos", alu_bus.res, 32'h0);
    apply_stimulus(4'b0010, 32'h8000_0000, 32'h7FFF_FFFF);
    check_output("slt_min_max", alu_bus.res, 32'h1);
    apply_stimulus(4'b0011, 32'h8000_0000, 32'h7FFF_FFFF);
    check_output("sltu_min_max", alu_bus.res, 32'h0);
    apply_stimulus(4'b0010, 32'h0000_0005, 32'h0000_0005);
    check_output("slt_equal", alu_bus.res, 32'h0);

    apply_stimulus(4'b0001, 32'h8000_0001, 32'hFFFF_FFE4);
    check_output("sll_4", alu_bus.res, 32'h0000_0010);
    apply_stimulus(4'b0101, 32'h8000_0001, 32'hFFFF_FFE4);
    check_output("srl_4", alu_bus.res, 32'h0800_0000);
    apply_stimulus(4'b1101, 32'h8000_0001, 32'hFFFF_FFE4);
    check_output("sra_4", alu_bus.res, 32'hF800_0000);
    apply_stimulus(4'b0001, 32'h1234_5678, 32'hFFFF_FFE0);
    check_output("sll_0", alu_bus.res, 32'h1234_5678);
    apply_stimulus(4'b1101, 32'h8765_4321, 32'h0000_0000);
    check_output("sra_0", alu_bus.res, 32'h8765_4321);
    apply_stimulus(4'b1101, 32'h8000_0000, 32'h0000_001F);
    check_output("sra_31", alu_bus.res, 32'hFFFF_FFFF);
    apply_stimulus(4'b0101, 32'h8000_0000, 32'h0000_001F);
    check_output("srl_31", alu_bus.res, 32'h0000_0001);
    apply_stimulus(4'b1101, 32'h4000_0000, 32'h0000_0004);
    check_output("sra_pos", alu_bus.res, 32'h0400_0000);

    apply_stimulus(4'b0100, 32'hF0F0_F0F0, 32'h0FF0_0FF0);
    check_output("xor", alu_bus.res, 32'hFF00_FF00);
    apply_stimulus(4'b0110, 32'hF0F0_F0F0, 32'h0FF0_0FF0);
    check_output("or", alu_bus.res, 32'hFFF0_FFF0);
    apply_stimulus(4'b0111, 32'hF0F0_F0F0, 32'h0FF0_0FF0);
    check_output("and", alu_bus.res, 32'h00F0_00F0);
    for (int i = 0; i < 6; i++) begin
      apply_stimulus(undef_ops[i], 32'hF0F0_F0F0, 32'h0FF0_0FF0);
      check_output($sformatf("undef_%b", undef_ops[i]), alu_bus.res, 32'h0);
    end

`ifdef ALU_BRANCH_CMP_EN
    apply_stimulus(4'b1111, 32'h8000_0000, 32'h7FFF_FFFF);
    check_output("cmp_eq_diff", {31'b0, alu_bus.eq}, 32'h0);
    check_output("cmp_lt_signed", {31'b0, alu_bus.lt}, 32'h1);
    check_output("cmp_ltu_unsigned", {31'b0, alu_bus.ltu}, 32'h0);
    apply_stimulus(4'b0000, 32'h0000_1234, 32'h0000_1234);
    check_output("cmp_eq_same", {31'b0, alu_bus.eq}, 32'h1);
    check_output("cmp_lt_same", {31'b0, alu_bus.lt}, 32'h0);
`endif

    // Random sweep: combinational result each cycle, then its registered copy after the edge
    for (int n = 0; n < 1000; n++) begin
      rop = ops[$urandom_range(0, 9)];
      ra  = $urandom;
      rb  = $urandom;
      if (n % 8 == 0) rb = 32'(n % 32);
      apply_stimulus(rop, ra, rb);
      exp_prev = ref_alu(rop, ra, rb);
      check_output($sformatf("rand_res_op%b", rop), alu_bus.res, exp_prev);
      clock_edge();
      check_output("rand_res_q", alu_bus.res_q, exp_prev);
      check_output("rand_zero_q", {31'b0, alu_bus.zero_q}, {31'b0, exp_prev == 32'h0});
    end

    // Mid-stream reset held for two edges while inputs keep changing
    apply_stimulus(4'b0000, 32'h0000_0005, 32'h0000_0006);
    reset = 1'b1;
    clock_edge();
    check_output("midrst1_res_q", alu_bus.res_q, 32'h0);
    check_output("midrst1_zero_q", {31'b0, alu_bus.zero_q}, 32'h1);
    check_output("midrst1_res", alu_bus.res, 32'h0000_000B);
    apply_stimulus(4'b0000, 32'h0000_0007, 32'h0000_0001);
    check_output("midrst2_res", alu_bus.res, 32'h0000_0008);
    clock_edge();
    check_output("midrst2_res_q", alu_bus.res_q, 32'h0);
    check_output("midrst2_zero_q", {31'b0, alu_bus.zero_q}, 32'h1);
    @(negedge clk);
    reset = 1'b0;
    clock_edge();
    check_output("postrst_res_q", alu_bus.res_q, 32'h0000_0008);
    check_output("postrst_zero_q", {31'b0, alu_bus.zero_q}, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
